// File: rtl/fiat_25519_carry_mul_limb_acc_pkg.sv
// fiat_25519_carry_mul_pkg: shared constants, FSM states and limb-width helper for the carry-mul datapath
package fiat_25519_carry_mul_pkg;
    localparam int IN_W        = 32;
    localparam int ACC_W       = 64;
    localparam int TERMS       = 10;
    localparam int NLIMBS      = 10;
    localparam int LIMB_W_EVEN = 26;
    localparam int LIMB_W_ODD  = 25;
    typedef enum logic {ACC, EMIT} state_e;
    function automatic int limb_width(input logic [3:0] idx);
        return idx[0] ? LIMB_W_ODD : LIMB_W_EVEN;
    endfunction
endpackage

// File: rtl/fiat_25519_carry_mul_limb_acc_if.sv
// fiat_25519_carry_mul_limb_acc_if: product-term input and limb output handshakes
interface fiat_25519_carry_mul_limb_acc_if;
    import fiat_25519_carry_mul_pkg::*;
    logic                   in_valid;
    logic                   in_ready;
    logic [IN_W-1:0]        in_data;
    logic                   out_valid;
    logic                   out_ready;
    logic [LIMB_W_EVEN-1:0] out_limb;
    logic [3:0]             out_idx;
    logic                   out_last;
    logic [ACC_W-1:0]       carry_out;
    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_limb, out_idx, out_last, carry_out);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_limb, out_idx, out_last, carry_out);
endinterface

// File: rtl/fiat_25519_carry_mul_carry_split.sv
// fiat_25519_carry_mul_carry_split: split a signed sum into a 26/25-bit unsigned limb and a signed carry
module fiat_25519_carry_mul_carry_split
    import fiat_25519_carry_mul_pkg::*;
(
    input  logic [ACC_W-1:0]       sum_i,
    input  logic                   odd_i,
    output logic [LIMB_W_EVEN-1:0] limb_o,
    output logic [ACC_W-1:0]       carry_o
);
    always_comb begin
        limb_o  = odd_i ? {1'b0, sum_i[LIMB_W_ODD-1:0]} : sum_i[LIMB_W_EVEN-1:0];
        carry_o = odd_i ? $signed(sum_i) >>> LIMB_W_ODD : $signed(sum_i) >>> LIMB_W_EVEN;
    end
endmodule

// File: rtl/fiat_25519_carry_mul_limb_acc.sv
// fiat_25519_carry_mul_limb_acc: accumulate TERMS signed products per limb, split into limb + carry,
// chain the carry into the next limb and export the final carry with the last limb
module fiat_25519_carry_mul_limb_acc
    import fiat_25519_carry_mul_pkg::*;
(
    input  logic                            ap_clk,
    input  logic                            ap_rst,
    fiat_25519_carry_mul_limb_acc_if.slave  bus
);
    state_e                 state_q, state_d;
    logic [ACC_W-1:0]       acc_q, acc_d, carry_q, carry_d, sum, split_carry;
    logic [3:0]             term_cnt_q, term_cnt_d, limb_idx_q, limb_idx_d;
    logic [LIMB_W_EVEN-1:0] limb_q, limb_d, split_limb;
    logic                   last;

    assign sum  = acc_q + {{(ACC_W-IN_W){bus.in_data[IN_W-1]}}, bus.in_data};
    assign last = limb_idx_q == 4'(NLIMBS-1);

    fiat_25519_carry_mul_carry_split u_split (
        .sum_i   (sum),
        .odd_i   (limb_width(limb_idx_q) == LIMB_W_ODD),
        .limb_o  (split_limb),
        .carry_o (split_carry)
    );

    always_comb begin
        state_d    = state_q;
        acc_d      = acc_q;
        carry_d    = carry_q;
        term_cnt_d = term_cnt_q;
        limb_idx_d = limb_idx_q;
        limb_d     = limb_q;
        if (state_q == ACC && bus.in_valid) begin
            if (term_cnt_q == 4'(TERMS-1)) begin
                limb_d     = split_limb;
                carry_d    = split_carry;
                term_cnt_d = '0;
                state_d    = EMIT;
            end else begin
                acc_d      = sum;
                term_cnt_d = term_cnt_q + 4'd1;
            end
        end else if (state_q == EMIT && bus.out_ready) begin
            state_d    = ACC;
            acc_d      = last ? '0 : carry_q;
            carry_d    = last ? '0 : carry_q;
            limb_idx_d = last ? '0 : limb_idx_q + 4'd1;
        end
    end

    always_ff @(posedge ap_clk or posedge ap_rst) begin
        if (ap_rst) begin
            state_q    <= ACC;
            acc_q      <= '0;
            carry_q    <= '0;
            term_cnt_q <= '0;
            limb_idx_q <= '0;
            limb_q     <= '0;
        end else begin
            state_q    <= state_d;
            acc_q      <= acc_d;
            carry_q    <= carry_d;
            term_cnt_q <= term_cnt_d;
            limb_idx_q <= limb_idx_d;
            limb_q     <= limb_d;
        end
    end

    assign bus.in_ready  = state_q == ACC;
    assign bus.out_valid = state_q == EMIT;
    assign bus.out_limb  = limb_q;
    assign bus.out_idx   = limb_idx_q;
    assign bus.out_last  = state_q == EMIT && last;
    assign bus.carry_out = (state_q == EMIT && last) ? carry_q : '0;
endmodule
